nn_layer_sequencer: RTL and testbench

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

---
 rtl/nn_layer_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for a two-layer MLP (10-5-3) sharing one MAC unit.
// Define SEQ_BIAS_EN to add a bias MAC cycle after each neuron's inputs.
module nn_layer_sequencer (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Stall,
    output logic       Busy,
    output logic       Done,
    output logic [6:0] Address,
    output logic [3:0] InSel,
    output logic [2:0] NeuronIdx,
    output logic       Layer,
    output logic       AccClr,
    output logic       AccEn,
    output logic       ActWrite,
    output logic [3:0] State
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] H_CLR  = 4'd1;
    localparam logic [3:0] H_MAC  = 4'd2;
    localparam logic [3:0] H_ACT  = 4'd3;
    localparam logic [3:0] O_CLR  = 4'd4;
    localparam logic [3:0] O_MAC  = 4'd5;
    localparam logic [3:0] O_ACT  = 4'd6;
    localparam logic [3:0] DONE   = 4'd7;
    localparam logic [3:0] H_BIAS = 4'd8;
    localparam logic [3:0] O_BIAS = 4'd9;

    logic [3:0] state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx_n;
    logic       lay_n;
    logic [6:0] addr_n;
    logic [3:0] sel_n;
    logic       legal;

    assign State = state;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            NeuronIdx <= 3'd0;
            Layer     <= 1'b0;
            Address   <= 7'd0;
            InSel     <= 4'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            NeuronIdx <= idx_n;
            Layer     <= lay_n;
            Address   <= addr_n;
            InSel     <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = NeuronIdx;
        lay_n   = Layer;
        legal   = 1'b1;
        case (state)
            IDLE: if (Start) begin
                state_n = H_CLR;
                idx_n   = 3'd0;
                lay_n   = 1'b0;
            end
            H_CLR: begin
                state_n = H_MAC;
                cnt_n   = 4'd0;
            end
            H_MAC: begin
                if (cnt >= 4'd9) begin
`ifdef SEQ_BIAS_EN
                    state_n = H_BIAS;
`else
                    state_n = H_ACT;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            H_ACT: begin
                if (NeuronIdx >= 3'd4) begin
                    state_n = O_CLR;
                    idx_n   = 3'd0;
                    lay_n   = 1'b1;
                end else begin
                    state_n = H_CLR;
                    idx_n   = NeuronIdx + 3'd1;
                end
            end
            O_CLR: begin
                state_n = O_MAC;
                cnt_n   = 4'd0;
            end
            O_MAC: begin
                if (cnt >= 4'd4) begin
`ifdef SEQ_BIAS_EN
                    state_n = O_BIAS;
`else
                    state_n = O_ACT;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            O_ACT: begin
                if (NeuronIdx >= 3'd2) begin
                    state_n = DONE;
                end else begin
                    state_n = O_CLR;
                    idx_n   = NeuronIdx + 3'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = 3'd0;
                lay_n   = 1'b0;
            end
`ifdef SEQ_BIAS_EN
            H_BIAS: state_n = H_ACT;
            O_BIAS: state_n = O_ACT;
`endif
            default: begin
                legal   = 1'b0;
                state_n = IDLE;
                cnt_n   = 4'd0;
                idx_n   = 3'd0;
                lay_n   = 1'b0;
            end
        endcase
        // Illegal states still recover while stalled
        if (Stall && legal) begin
            state_n = state;
            cnt_n   = cnt;
            idx_n   = NeuronIdx;
            lay_n   = Layer;
        end
    end

    always_comb begin
        addr_n = Address;
        sel_n  = InSel;
        case (state_n)
            H_MAC: begin
                addr_n = {4'd0, idx_n} * 7'd10 + {3'd0, cnt_n};
                sel_n  = cnt_n;
            end
            O_MAC: begin
                addr_n = 7'd50 + {4'd0, idx_n} * 7'd5 + {3'd0, cnt_n};
                sel_n  = cnt_n;
            end
`ifdef SEQ_BIAS_EN
            H_BIAS: begin
                addr_n = 7'd65 + {4'd0, idx_n};
                sel_n  = 4'hF;
            end
            O_BIAS: begin
                addr_n = 7'd70 + {4'd0, idx_n};
                sel_n  = 4'hF;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        Busy     = (state != IDLE);
        AccClr   = !Stall && (state == H_CLR || state == O_CLR);
`ifdef SEQ_BIAS_EN
        AccEn    = !Stall && (state == H_MAC || state == O_MAC ||
                              state == H_BIAS || state == O_BIAS);
`else
        AccEn    = !Stall && (state == H_MAC || state == O_MAC);
`endif
        ActWrite = !Stall && (state == H_ACT || state == O_ACT);
        Done     = !Stall && (state == DONE);
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: pass schedule model, random start/stall.
// Honours SEQ_BIAS_EN when defined for the build.
module tb_nn_layer_sequencer;

    logic       Clock, Rst, Start, Stall;
    logic       Busy, Done, Layer, AccClr, AccEn, ActWrite;
    logic [6:0] Address;
    logic [3:0] InSel, State;
    logic [2:0] NeuronIdx;

    nn_layer_sequencer dut (
        .Clock(Clock), .Rst(Rst), .Start(Start), .Stall(Stall),
        .Busy(Busy), .Done(Done), .Address(Address), .InSel(InSel),
        .NeuronIdx(NeuronIdx), .Layer(Layer), .AccClr(AccClr),
        .AccEn(AccEn), .ActWrite(ActWrite), .State(State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef SEQ_BIAS_EN
    localparam int LAT  = 90;
    localparam bit BIAS = 1'b1;
`else
    localparam int LAT  = 82;
    localparam bit BIAS = 1'b0;
`endif

    typedef struct {
        logic [3:0] st;
        logic       mac;
        logic [6:0] addr;
        logic [3:0] sel;
        logic [2:0] idx;
        logic       lay;
    } item_t;

    item_t pass_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    in_pass = 0;
    int    pos = 0;
    int    ecount = 0;
    int    e0 = 0;
    int    stalls = 0;
    int    acts = 0;
    logic [6:0] last_addr = 7'd0;
    logic [3:0] last_sel = 4'd0;

    function automatic item_t mk(input logic [3:0] st, input logic mac,
                                 input int a, input int s,
                                 input int n, input int l);
        item_t it;
        it.st   = st;
        it.mac  = mac;
        it.addr = 7'(a);
        it.sel  = 4'(s);
        it.idx  = 3'(n);
        it.lay  = l[0];
        return it;
    endfunction

    // Whole-pass schedule derived from layer sizes
    task automatic build_pass();
        pass_q.delete();
        for (int n = 0; n < 5; n++) begin
            pass_q.push_back(mk(4'd1, 0, 0, 0, n, 0));
            for (int i = 0; i < 10; i++)
                pass_q.push_back(mk(4'd2, 1, n*10+i, i, n, 0));
            if (BIAS) pass_q.push_back(mk(4'd8, 1, 65+n, 15, n, 0));
            pass_q.push_back(mk(4'd3, 0, 0, 0, n, 0));
        end
        for (int n = 0; n < 3; n++) begin
            pass_q.push_back(mk(4'd4, 0, 0, 0, n, 1));
            for (int i = 0; i < 5; i++)
                pass_q.push_back(mk(4'd5, 1, 50+n*5+i, i, n, 1));
            if (BIAS) pass_q.push_back(mk(4'd9, 1, 70+n, 15, n, 1));
            pass_q.push_back(mk(4'd6, 0, 0, 0, n, 1));
        end
        pass_q.push_back(mk(4'd7, 0, 0, 0, 2, 1));
    endtask

    function automatic item_t cur();
        if (in_pass) return pass_q[pos];
        return mk(4'd0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string tag);
        item_t it;
        logic [23:0] exp, obs;
        logic cl, en, ac, dn;
        int rel;
        it = cur();
        if (it.mac) begin
            last_addr = it.addr;
            last_sel  = it.sel;
        end
        cl = !Stall && (it.st == 4'd1 || it.st == 4'd4);
        en = !Stall && it.mac;
        ac = !Stall && (it.st == 4'd3 || it.st == 4'd6);
        dn = !Stall && (it.st == 4'd7);
        exp = {it.st, it.st != 4'd0, dn, cl, en, ac,
               last_addr, last_sel, it.idx, it.lay};
        obs = {State, Busy, Done, AccClr, AccEn, ActWrite,
               Address, InSel, NeuronIdx, Layer};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d outputs got=%h want=%h",
                   tag, ecount, obs, exp);
        end
        if (in_pass && Done === 1'b1) begin
            rel = ecount - e0;
            vectors++;
            assert (rel === LAT + stalls) else begin
                miscompares++;
                $error("FAIL %s latency got=%0d want=%0d",
                       tag, rel, LAT + stalls);
            end
            vectors++;
            assert (acts === 8) else begin
                miscompares++;
                $error("FAIL %s actwrites got=%0d want=8", tag, acts);
            end
        end
        if (ActWrite === 1'b1) acts++;
    endtask

    task automatic cyc(input logic st, input logic sl, input string tag);
        Start = st;
        Stall = sl;
        #3;
        check(tag);
        @(posedge Clock);
        if (!in_pass) begin
            if (st && !sl) begin
                in_pass = 1;
                pos     = 0;
                e0      = ecount;
                stalls  = 0;
                acts    = 0;
            end
        end else if (sl) begin
            stalls++;
        end else begin
            pos++;
            if (pos == pass_q.size()) in_pass = 0;
        end
        ecount++;
        #1;
    endtask

    // smode: 0 none, 1 random, 2 only in DONE; sdiv: stall 1-in-N
    task automatic finish_pass(input int smode, input int sdiv,
                               input string tag);
        int k;
        logic st, sl;
        k = 0;
        while (in_pass && k < 600) begin
            st = 1'b0;
            if (smode == 1) st = ($urandom_range(0, 3) == 0);
            if (smode == 2) st = (pass_q[pos].st == 4'd7);
            sl = (sdiv > 0) ? ($urandom_range(0, sdiv-1) == 0) : 1'b0;
            cyc(st, sl, tag);
            k++;
        end
        vectors++;
        assert (k < 600) else begin
            miscompares++;
            $error("FAIL %s timeout got=%0d want<600", tag, k);
        end
    endtask

    task automatic run_to_addr(input logic [6:0] a, input string tag);
        int k;
        k = 0;
        while (!(in_pass && pass_q[pos].mac && pass_q[pos].addr == a)
               && k < 200) begin
            cyc(1'b0, 1'b0, tag);
            k++;
        end
        vectors++;
        assert (k < 200) else begin
            miscompares++;
            $error("FAIL %s seek got=%0d want<200", tag, k);
        end
    endtask

    task automatic model_reset();
        in_pass   = 0;
        last_addr = 7'd0;
        last_sel  = 4'd0;
    endtask

    logic [23:0] rv;

    initial begin
        build_pass();
        Rst = 1'b0; Start = 1'b0; Stall = 1'b0;
        #1 Rst = 1'b1;
        #2;
        rv = {State, Busy, Done, AccClr, AccEn, ActWrite,
              Address, InSel, NeuronIdx, Layer};
        vectors++;
        assert (rv === 24'd0) else begin
            miscompares++;
            $error("FAIL reset_init got=%h want=0", rv);
        end
        @(posedge Clock); @(posedge Clock);
        #1 Rst = 1'b0;
        model_reset();

        cyc(1'b0, 1'b0, "idle");
        cyc(1'b1, 1'b1, "stall_blocks_start");
        cyc(1'b0, 1'b0, "idle2");

        cyc(1'b1, 1'b0, "p1_start");
        finish_pass(2, 0, "p1");
        cyc(1'b0, 1'b0, "p1_after");

        cyc(1'b1, 1'b0, "p2_start");
        run_to_addr(7'd23, "p2_seek");
        repeat (5) cyc(1'b0, 1'b1, "p2_stall23");
        finish_pass(0, 0, "p2");
        cyc(1'b0, 1'b0, "p2_after");

        repeat (2 * (LAT + 2) + 3) cyc(1'b1, 1'b0, "held_start");
        finish_pass(0, 0, "held_tail");

        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 1'b0, "rnd_start");
            finish_pass(1, 6, "rnd");
            cyc(1'b0, $urandom_range(0, 1) == 1, "rnd_idle");
        end

        cyc(1'b1, 1'b0, "rst_start");
        run_to_addr(7'd57, "rst_seek");
        Start = 1'b0; Stall = 1'b0;
        #2;
        check("pre_rst");
        #1 Rst = 1'b1;
        #1;
        rv = {State, Busy, Done, AccClr, AccEn, ActWrite,
              Address, InSel, NeuronIdx, Layer};
        vectors++;
        assert (rv === 24'd0) else begin
            miscompares++;
            $error("FAIL reset_async got=%h want=0", rv);
        end
        model_reset();
        @(posedge Clock);
        #1 Rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, "post_rst_idle");
        cyc(1'b1, 1'b0, "clean_start");
        finish_pass(0, 0, "clean");
        cyc(1'b0, 1'b0, "clean_after");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
